// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station and any CDB broadcaster.
// Holds the tag/data widths, the "value present" tag encoding, the entry
// record layout and the CDB tag-match helper used for snoop and bypass.
package reservation_station_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    // Tag value meaning "operand value is already present"; the CDB
    // broadcaster must never drive a real result with this tag.
    localparam logic [TAG_W-1:0] INVALID_TAG = 6'b010000;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
    } rs_entry_t;

    // True when a valid CDB broadcast produces the value that source tag q waits on.
    function automatic logic cdb_hit(
        input logic             cdb_valid,
        input logic [TAG_W-1:0] cdb_rob,
        input logic [TAG_W-1:0] q
    );
        return cdb_valid && (cdb_rob != INVALID_TAG) && (q == cdb_rob);
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot.
// Ports:
//   clock, rst_n        clock and asynchronous active-low reset
//   flush               squash: clears busy, wins over everything else
//   alloc               write a new instruction into this (free) slot
//   issue_*             instruction fields offered at allocation
//   cdb_valid/rob/data  result broadcast, snooped by a busy slot and
//                       bypassed into a slot being allocated
//   dispatch            slot was handed to the functional unit this cycle
//   entry               registered slot contents
module rs_entry
    import reservation_station_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [TAG_W-1:0]  issue_dest,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_rob,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              dispatch,
    output rs_entry_t         entry
);

    rs_entry_t entry_r;
    rs_entry_t entry_next_s;

    // Next-state: flush, then allocation with bypass, then snoop/dispatch of a busy slot.
    always_comb begin
        entry_next_s = entry_r;
        if (flush) begin
            entry_next_s.busy = 1'b0;
        end else if (alloc) begin
            entry_next_s.busy = 1'b1;
            entry_next_s.op   = issue_op;
            entry_next_s.dest = issue_dest;
            if (cdb_hit(cdb_valid, cdb_rob, issue_qj)) begin
                entry_next_s.qj = INVALID_TAG;
                entry_next_s.vj = cdb_data;
            end else begin
                entry_next_s.qj = issue_qj;
                entry_next_s.vj = issue_vj;
            end
            if (cdb_hit(cdb_valid, cdb_rob, issue_qk)) begin
                entry_next_s.qk = INVALID_TAG;
                entry_next_s.vk = cdb_data;
            end else begin
                entry_next_s.qk = issue_qk;
                entry_next_s.vk = issue_vk;
            end
        end else if (entry_r.busy) begin
            // Both operands snoop independently; a capture only becomes
            // visible as "ready" from the registered value next cycle.
            if (cdb_hit(cdb_valid, cdb_rob, entry_r.qj)) begin
                entry_next_s.qj = INVALID_TAG;
                entry_next_s.vj = cdb_data;
            end else begin
                entry_next_s.qj = entry_r.qj;
                entry_next_s.vj = entry_r.vj;
            end
            if (cdb_hit(cdb_valid, cdb_rob, entry_r.qk)) begin
                entry_next_s.qk = INVALID_TAG;
                entry_next_s.vk = cdb_data;
            end else begin
                entry_next_s.qk = entry_r.qk;
                entry_next_s.vk = entry_r.vk;
            end
            if (dispatch) begin
                entry_next_s.busy = 1'b0;
            end else begin
                entry_next_s.busy = 1'b1;
            end
        end else begin
            entry_next_s = entry_r;
        end
    end

    // Slot state register; reset leaves both source tags at "value present".
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '{busy: 1'b0,
                         op:   {OP_W{1'b0}},
                         dest: INVALID_TAG,
                         qj:   INVALID_TAG,
                         vj:   {DATA_W{1'b0}},
                         qk:   INVALID_TAG,
                         vk:   {DATA_W{1'b0}}};
        end else begin
            entry_r <= entry_next_s;
        end
    end

    assign entry = entry_r;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: ENTRIES slots waiting on operand tags, fed from issue,
// woken by CDB broadcasts and drained into one functional unit.
// Operand/tag/opcode widths are those of reservation_station_pkg; the
// parameters exist for interface documentation and must keep those values.
// Ports:
//   clock, rst_n                 clock, asynchronous active-low reset
//   issue_valid/issue_ready      issue handshake (ready = some slot free)
//   issue_op/dest/qj/qk/vj/vk    instruction; qX==INVALID_TAG means vX valid
//   cdb_valid/cdb_rob/cdb_data   result broadcast
//   ex_valid/ex_ready            dispatch handshake to the functional unit
//   ex_op/ex_dest/ex_a/ex_b      lowest-index ready slot
//   flush                        synchronous squash of all slots
//   count                        number of busy slots
module reservation_station #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = reservation_station_pkg::DATA_W,
    parameter int TAG_W   = reservation_station_pkg::TAG_W,
    parameter int OP_W    = reservation_station_pkg::OP_W
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [OP_W-1:0]              issue_op,
    input  logic [TAG_W-1:0]             issue_dest,
    input  logic [TAG_W-1:0]             issue_qj,
    input  logic [TAG_W-1:0]             issue_qk,
    input  logic [DATA_W-1:0]            issue_vj,
    input  logic [DATA_W-1:0]            issue_vk,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_rob,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [OP_W-1:0]              ex_op,
    output logic [TAG_W-1:0]             ex_dest,
    output logic [DATA_W-1:0]            ex_a,
    output logic [DATA_W-1:0]            ex_b,
    input  logic                         flush,
    output logic [$clog2(ENTRIES+1)-1:0] count
);

    import reservation_station_pkg::*;

    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam logic [ENTRIES-1:0] ONE_E = {{(ENTRIES-1){1'b0}}, 1'b1};

    rs_entry_t          entry_s [ENTRIES];
    logic [ENTRIES-1:0] busy_s;
    logic [ENTRIES-1:0] ready_s;
    logic [ENTRIES-1:0] free_first_s;
    logic [ENTRIES-1:0] ready_first_s;
    logic [ENTRIES-1:0] alloc_s;
    logic [ENTRIES-1:0] dispatch_s;
    logic               do_issue_s;
    logic               do_dispatch_s;
    rs_entry_t          sel_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        rs_entry u_entry (
            .clock      (clock),
            .rst_n      (rst_n),
            .flush      (flush),
            .alloc      (alloc_s[g]),
            .issue_op   (issue_op),
            .issue_dest (issue_dest),
            .issue_qj   (issue_qj),
            .issue_qk   (issue_qk),
            .issue_vj   (issue_vj),
            .issue_vk   (issue_vk),
            .cdb_valid  (cdb_valid),
            .cdb_rob    (cdb_rob),
            .cdb_data   (cdb_data),
            .dispatch   (dispatch_s[g]),
            .entry      (entry_s[g])
        );
        assign busy_s[g]  = entry_s[g].busy;
        assign ready_s[g] = entry_s[g].busy &&
                            (entry_s[g].qj == INVALID_TAG) &&
                            (entry_s[g].qk == INVALID_TAG);
    end

    // Handshakes and lowest-set-bit pickers (x & -x) for allocation and dispatch.
    always_comb begin
        issue_ready   = ~&busy_s;
        ex_valid      = |ready_s;
        do_issue_s    = issue_valid && issue_ready && !flush;
        do_dispatch_s = ex_valid && ex_ready && !flush;
        free_first_s  = ~busy_s & (busy_s + ONE_E);
        ready_first_s = ready_s & (~ready_s + ONE_E);
        alloc_s       = do_issue_s ? free_first_s : {ENTRIES{1'b0}};
        dispatch_s    = do_dispatch_s ? ready_first_s : {ENTRIES{1'b0}};
    end

    // Dispatch mux: idle value (op 0, dest INVALID_TAG, operands 0) when nothing is ready.
    always_comb begin
        sel_s = '{busy: 1'b0, op: {OP_W{1'b0}}, dest: INVALID_TAG,
                  qj: INVALID_TAG, vj: {DATA_W{1'b0}},
                  qk: INVALID_TAG, vk: {DATA_W{1'b0}}};
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready_first_s[i]) begin
                sel_s = entry_s[i];
            end else begin
                sel_s = sel_s;
            end
        end
        ex_op   = sel_s.op;
        ex_dest = sel_s.dest;
        ex_a    = sel_s.vj;
        ex_b    = sel_s.vk;
    end

    // Occupancy next-state: flush empties, issue and dispatch may both apply.
    always_comb begin
        if (flush) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = count_r + CNT_W'(do_issue_s) - CNT_W'(do_dispatch_s);
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared every cycle against a slot-array reference model kept here.
module tb_reservation_station;

    localparam logic [5:0] INV = 6'd16;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  issue_op = 4'd0;
    logic [5:0]  issue_dest = 6'd0;
    logic [5:0]  issue_qj = INV;
    logic [5:0]  issue_qk = INV;
    logic [31:0] issue_vj = 32'd0;
    logic [31:0] issue_vk = 32'd0;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_rob = 6'd0;
    logic [31:0] cdb_data = 32'd0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [3:0]  ex_op;
    logic [5:0]  ex_dest;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        flush = 1'b0;
    logic [2:0]  count;

    reservation_station dut (
        .clock(clock), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_dest(ex_dest), .ex_a(ex_a), .ex_b(ex_b),
        .flush(flush), .count(count)
    );

    always #5 clock = ~clock;

    // Reference model: one record per slot.
    bit          m_busy [4];
    logic [3:0]  m_op   [4];
    logic [5:0]  m_dest [4];
    logic [5:0]  m_qj   [4];
    logic [5:0]  m_qk   [4];
    logic [31:0] m_vj   [4];
    logic [31:0] m_vk   [4];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int first_ready();
        for (int i = 0; i < 4; i++)
            if (m_busy[i] && m_qj[i] == INV && m_qk[i] == INV) return i;
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < 4; i++)
            if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic check_all(input string tag);
        int sel;
        int occ;
        sel = first_ready();
        occ = 0;
        for (int i = 0; i < 4; i++) occ += int'(m_busy[i]);
        chk({tag, ".issue_ready"}, 64'(issue_ready), 64'(occ < 4));
        chk({tag, ".count"}, 64'(count), 64'(occ));
        chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(sel >= 0));
        if (sel >= 0) begin
            chk({tag, ".ex_op"},   64'(ex_op),   64'(m_op[sel]));
            chk({tag, ".ex_dest"}, 64'(ex_dest), 64'(m_dest[sel]));
            chk({tag, ".ex_a"},    64'(ex_a),    64'(m_vj[sel]));
            chk({tag, ".ex_b"},    64'(ex_b),    64'(m_vk[sel]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0; m_qj[i] = INV; m_qk[i] = INV;
        end
    endtask

    // Apply one clock edge of the spec's rules to the model using current inputs.
    task automatic model_step();
        int  fr, ds;
        bit  hit;
        if (flush) begin
            for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
        end else begin
            fr  = first_free();
            ds  = first_ready();
            hit = cdb_valid && cdb_rob != INV;
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i] && hit && m_qj[i] == cdb_rob) begin m_qj[i] = INV; m_vj[i] = cdb_data; end
                if (m_busy[i] && hit && m_qk[i] == cdb_rob) begin m_qk[i] = INV; m_vk[i] = cdb_data; end
            end
            if (ds >= 0 && ex_ready) m_busy[ds] = 1'b0;
            if (issue_valid && fr >= 0) begin
                m_busy[fr] = 1'b1; m_op[fr] = issue_op; m_dest[fr] = issue_dest;
                m_qj[fr] = issue_qj; m_vj[fr] = issue_vj;
                m_qk[fr] = issue_qk; m_vk[fr] = issue_vk;
                if (hit && issue_qj == cdb_rob) begin m_qj[fr] = INV; m_vj[fr] = cdb_data; end
                if (hit && issue_qk == cdb_rob) begin m_qk[fr] = INV; m_vk[fr] = cdb_data; end
            end
        end
    endtask

    // Inputs are set at the falling edge; check, update model, advance one cycle.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        issue_valid = 1'b0; cdb_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        issue_qj = INV; issue_qk = INV;
    endtask

    task automatic issue(input logic [3:0] op, input logic [5:0] dest,
                         input logic [5:0] qj, input logic [31:0] vj,
                         input logic [5:0] qk, input logic [31:0] vk);
        issue_valid = 1'b1; issue_op = op; issue_dest = dest;
        issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
    endtask

    task automatic bcast(input logic [5:0] rob, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_rob = rob; cdb_data = data;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".ex_op"},   64'(ex_op),   64'(4'd0));
        chk({tag, ".ex_dest"}, 64'(ex_dest), 64'(INV));
        chk({tag, ".ex_a"},    64'(ex_a),    64'(32'd0));
        chk({tag, ".ex_b"},    64'(ex_b),    64'(32'd0));
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        idle();
        @(negedge clock);
        apply_reset("reset");
        tick("post_reset");

        // Ready-at-issue instruction dispatches next cycle.
        issue(4'd3, 6'd5, INV, 32'd7, INV, 32'd9); tick("basic_issue");
        idle(); ex_ready = 1'b1;
        #1; chk("basic.ex_a", 64'(ex_a), 64'(32'd7)); chk("basic.ex_dest", 64'(ex_dest), 64'(6'd5));
        tick("basic_dispatch");
        idle(); tick("basic_empty");

        // Wake-up through snoop.
        issue(4'd1, 6'd8, 6'd2, 32'd0, INV, 32'd4); tick("snoop_issue");
        idle(); tick("snoop_wait");
        bcast(6'd2, 32'h11); tick("snoop_bcast");
        idle(); #1; chk("snoop.ex_a", 64'(ex_a), 64'(32'h11));
        ex_ready = 1'b1; tick("snoop_dispatch");
        idle(); tick("snoop_empty");

        // Same-cycle bypass at allocation, and an INVALID_TAG broadcast that must be ignored.
        issue(4'd2, 6'd9, 6'd3, 32'd1, INV, 32'd6); bcast(6'd3, 32'hAA); tick("bypass_issue");
        idle(); #1; chk("bypass.ex_a", 64'(ex_a), 64'(32'hAA));
        ex_ready = 1'b1; tick("bypass_dispatch");
        idle(); issue(4'd4, 6'd10, INV, 32'd5, INV, 32'd6); bcast(INV, 32'hDEAD); tick("inv_bcast");
        idle(); ex_ready = 1'b1; tick("inv_dispatch");
        idle(); tick("inv_empty");

        // Fill, reject a fifth issue, resolve slot 2 and dispatch it.
        for (int i = 0; i < 4; i++) begin
            issue(4'(i), 6'(20 + i), 6'(40 + i), 32'd0, INV, 32'(i)); tick("fill");
        end
        issue(4'd9, 6'd30, INV, 32'd1, INV, 32'd1); tick("full_reject");
        idle(); #1; chk("full.count", 64'(count), 64'(3'd4)); chk("full.issue_ready", 64'(issue_ready), 64'(1'b0));
        bcast(6'd42, 32'h55); tick("full_bcast");
        idle(); ex_ready = 1'b1; tick("full_dispatch");
        idle(); #1; chk("full.issue_ready_after", 64'(issue_ready), 64'(1'b1));
        tick("full_after");
        flush = 1'b1; tick("flush_full");
        idle(); tick("flush_after");

        // Two ready slots held under back-pressure, then drained in order.
        issue(4'd5, 6'd1, INV, 32'h100, INV, 32'h101); tick("bp_issue0");
        issue(4'd6, 6'd2, INV, 32'h200, INV, 32'h201); tick("bp_issue1");
        idle();
        for (int i = 0; i < 3; i++) begin
            #1; chk("bp.hold_dest", 64'(ex_dest), 64'(6'd1));
            tick("bp_hold");
        end
        ex_ready = 1'b1; tick("bp_drain0");
        #1; chk("bp.second_dest", 64'(ex_dest), 64'(6'd2));
        tick("bp_drain1");
        idle(); tick("bp_empty");

        // Flush with three busy slots; later broadcasts must not revive them.
        for (int i = 0; i < 3; i++) begin
            issue(4'd7, 6'(50 + i), 6'(i + 1), 32'd0, INV, 32'd0); tick("fl_fill");
        end
        idle(); flush = 1'b1; ex_ready = 1'b1; bcast(6'd1, 32'h77); tick("fl_flush");
        idle(); bcast(6'd2, 32'h78); ex_ready = 1'b1; tick("fl_bcast");
        idle(); #1; chk("fl.count", 64'(count), 64'(3'd0)); chk("fl.ex_valid", 64'(ex_valid), 64'(1'b0));
        tick("fl_after");

        // Reset mid-operation with three busy slots.
        for (int i = 0; i < 3; i++) begin
            issue(4'd8, 6'(55 + i), 6'(i + 4), 32'd0, INV, 32'd0); tick("rs_fill");
        end
        idle();
        apply_reset("mid_reset");
        bcast(6'd4, 32'h99); ex_ready = 1'b1; tick("rs_bcast");
        idle(); tick("rs_after");

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_op    = 4'($urandom);
            issue_dest  = 6'($urandom);
            issue_qj    = ($urandom_range(0, 2) == 0) ? INV : 6'($urandom_range(1, 6));
            issue_qk    = ($urandom_range(0, 2) == 0) ? INV : 6'($urandom_range(1, 6));
            issue_vj    = $urandom;
            issue_vk    = $urandom;
            cdb_valid   = ($urandom_range(0, 1) == 1);
            cdb_rob     = ($urandom_range(0, 7) == 0) ? INV : 6'($urandom_range(1, 6));
            cdb_data    = $urandom;
            ex_ready    = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            tick("rand");
        end
        idle(); tick("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameters: ENTRIES, default 4, number of entries; DATA_W, default 32, operand width; TAG_W, default 6, ROB tag width; OP_W, default 4, opcode width.
REQ-002 SHALL have ports, one per line (name direction width meaning):
 clock  in  1  single clock, rising edge
 rst_n  in  1  asynchronous, active-low reset
 issue_valid  in  1  new instruction offered
 issue_ready  out  1  free entry available
 issue_op  in  OP_W  opcode
 issue_dest  in  TAG_W  destination ROB tag
 issue_qj / issue_qk  in  TAG_W  source tags; INVALID_TAG means the value is present
 issue_vj / issue_vk  in  DATA_W  source values, used when the tag is INVALID_TAG
 cdb_valid  in  1  CDB broadcast strobe for this cycle
 cdb_rob  in  TAG_W  broadcast ROB tag
 cdb_data  in  DATA_W  broadcast result
 ex_valid  out  1  ready instruction offered to the functional unit
 ex_ready  in  1  functional unit accepts
 ex_op  out  OP_W  dispatched opcode
 ex_dest  out  TAG_W  dispatched destination tag
 ex_a / ex_b  out  DATA_W  dispatched operands
 flush  in  1  synchronous squash of all entries
 count  out  $clog2(ENTRIES+1)  occupied entries

Function
REQ-003 Each entry SHALL hold: busy, op, dest, qj, vj, qk, vk.
REQ-004 issue_ready SHALL be 1 when at least one entry has busy=0 at the start of the cycle. It is combinational from registered busy bits.
REQ-005 On issue_valid&issue_ready&!flush, the lowest-index free entry SHALL be written at the clock edge with busy=1.
REQ-006 Same-cycle bypass SHALL apply at allocation: if cdb_valid and issue_qj==cdb_rob and issue_qj!=INVALID_TAG, the entry SHALL store vj=cdb_data and qj=INVALID_TAG. The same rule SHALL apply to qk/vk.
REQ-007 Snoop: for every busy entry whose qj==cdb_rob while cdb_valid=1, the entry SHALL set vj=cdb_data and qj=INVALID_TAG at the edge. qk SHALL be handled independently, and both operands may capture in one cycle.
REQ-008 cdb_valid with cdb_rob==INVALID_TAG SHALL be ignored.
REQ-009 An entry SHALL be ready when busy=1, qj==INVALID_TAG and qk==INVALID_TAG, all as registered values. A capture makes the entry ready no earlier than the next cycle.
REQ-010 ex_valid SHALL be 1 when any entry is ready. ex_op, ex_dest, ex_a and ex_b SHALL come from the lowest-index ready entry, combinationally from registers.
REQ-011 On ex_valid&ex_ready, the selected entry SHALL clear busy at the edge. A freed entry SHALL NOT be allocatable in the same cycle.
REQ-012 Outputs SHALL be held stable while ex_valid=1 and ex_ready=0, unless a lower-index entry becomes ready.
REQ-013 Simultaneous issue, dispatch and snoop in one cycle SHALL all take effect.
REQ-014 count SHALL equal the number of busy entries. It SHALL be incremented and decremented in the same cycle when issue and dispatch coincide.
REQ-015 flush SHALL clear all busy bits at the edge and SHALL override issue, snoop and dispatch in that cycle. ex_valid is still combinational in the flush cycle and SHALL be ignored downstream.
REQ-016 When the block is full, issue_valid SHALL be ignored. When it is empty, ex_valid SHALL be 0.

Reset
REQ-017 rst_n=0 SHALL asynchronously clear all busy bits and set qj=qk=INVALID_TAG.
REQ-018 Effect of REQ-017 on outputs: issue_ready=1, ex_valid=0, count=0, ex_op=0, ex_dest=INVALID_TAG, ex_a=0, ex_b=0.
REQ-019 Reset deassertion SHALL be synchronized externally. Reset mid-operation SHALL discard all entries with no dispatch.

Structure
REQ-020 A shared package SHALL hold INVALID_TAG (6'b010000), TAG_W, DATA_W and the entry struct/typedef. The CDB broadcaster SHALL use the same INVALID_TAG.
REQ-021 One sub-module, rs_entry, SHALL implement a single entry with its snoop and bypass logic. It SHALL be instantiated ENTRIES times; selection and count logic SHALL live in the top.

Verification
REQ-022 Issue op=3, dest=5, qj=qk=INVALID_TAG, vj=7, vk=9 -> next cycle ex_valid=1, ex_a=7, ex_b=9, ex_dest=5; ex_ready=1 -> count returns to 0.
REQ-023 Issue qj=2, vk=4 -> ex_valid=0. Then cdb_valid, cdb_rob=2, cdb_data=0x11 -> ex_valid=1 the following cycle with ex_a=0x11.
REQ-024 Issue qj=3 in the same cycle as a CDB broadcast rob=3, data=0xAA -> the entry stores 0xAA and is ready the next cycle (bypass).
REQ-025 Fill 4 entries with unresolved tags -> issue_ready=0, and a 5th issue_valid is ignored with count=4. One broadcast resolves entry 2 -> dispatch; issue_ready=1 on the cycle after the dispatch edge.
REQ-026 Two ready entries with ex_ready=0 for 3 cycles -> outputs stable from entry 0. Then ex_ready=1 -> entry 0 dispatches, then entry 1 dispatches.
REQ-027 flush, and separately rst_n=0 mid-operation with 3 busy entries -> count=0, ex_valid=0, and no later dispatch of the squashed entries.
